// File: rtl/arb_mux_pkg.sv
// Shared types and constants for the N-channel arbitrating output multiplexer.
package arb_mux_pkg;

  typedef enum logic {
    MODE_DIRECT = 1'b0,
    MODE_RR     = 1'b1
  } arb_mode_t;

  localparam int unsigned STAT_W = 16;
  localparam int unsigned N_MAX  = 16;

  // Width of a channel index for n channels; never narrower than one bit.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/arb_mux_n_if.sv
// Request/response bundle between N producers and the shared output register of arb_mux_n.
interface arb_mux_n_if
  import arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 5
);
  localparam int unsigned SELW = sel_w(N);

  arb_mode_t          mode;
  logic [SELW-1:0]    select;
  logic [N-1:0]       in_valid;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [SELW-1:0]    out_ch;
  logic               out_ready;

  modport master (
    output mode, select, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_ch
  );

  modport slave (
    input  mode, select, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_ch
  );

endinterface

// File: rtl/rr_picker.sv
// Rotate-priority search: first set req bit strictly after ptr, wrapping modulo N.
module rr_picker
  import arb_mux_pkg::*;
#(
  parameter int unsigned N = 5
) (
  input  logic [N-1:0]          req,
  input  logic [sel_w(N)-1:0]   ptr,
  output logic [N-1:0]          gnt_onehot,
  output logic [sel_w(N)-1:0]   gnt_idx,
  output logic                  any
);
  localparam int unsigned SELW = sel_w(N);

  function automatic logic [SELW-1:0] wrap_idx(input int unsigned p, input int unsigned k);
    return SELW'((p + k) % N);
  endfunction

  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      if (!any && req[wrap_idx(32'(ptr), k)]) begin
        any                               = 1'b1;
        gnt_idx                           = wrap_idx(32'(ptr), k);
        gnt_onehot[wrap_idx(32'(ptr), k)] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arb_mux_n.sv
// Registered N-channel multiplexer with direct-select or round-robin arbitration.
// Optional per-channel saturating grant counters when ARB_MUX_STATS_EN is defined.
module arb_mux_n
  import arb_mux_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned N     = 5
) (
  input  logic                Clk,
  input  logic                Reset,
  arb_mux_n_if.slave          bus
`ifdef ARB_MUX_STATS_EN
  ,
  input  logic [sel_w(N)-1:0] stat_sel,
  output logic [STAT_W-1:0]   stat_count
`endif
);
  localparam int unsigned     SELW = sel_w(N);
  localparam logic [SELW-1:0] LAST = SELW'(N - 1);

  if (N < 1 || N > N_MAX) begin : g_bad_n
    $error("arb_mux_n: N must be in 1..16");
  end

  logic [SELW-1:0]  ptr;
  logic             load_c;
  logic [SELW-1:0]  dir_ch_c;
  logic [N-1:0]     rr_gnt_c;
  logic [SELW-1:0]  rr_idx_c;
  logic             rr_any_c;
  logic [N-1:0]     gnt_c;
  logic [SELW-1:0]  win_c;
  logic             any_c;
  logic [WIDTH-1:0] win_data_c;

  // The output register may take a new word when empty or being drained this cycle.
  assign load_c = !bus.out_valid || bus.out_ready;

  // Out-of-range select codes fall back to the last channel.
  assign dir_ch_c = (32'(bus.select) < N) ? bus.select : LAST;

  rr_picker #(.N(N)) u_rr_picker (
    .req        (bus.in_valid),
    .ptr        (ptr),
    .gnt_onehot (rr_gnt_c),
    .gnt_idx    (rr_idx_c),
    .any        (rr_any_c)
  );

  always_comb begin
    gnt_c = '0;
    win_c = dir_ch_c;
    any_c = 1'b0;
    if (bus.mode == MODE_RR) begin
      gnt_c = rr_gnt_c;
      win_c = rr_idx_c;
      any_c = rr_any_c;
    end else if (bus.in_valid[dir_ch_c]) begin
      gnt_c[dir_ch_c] = 1'b1;
      any_c           = 1'b1;
    end
  end

  assign bus.in_ready = (load_c && !Reset) ? gnt_c : '0;
  assign win_data_c   = bus.in_data[32'(win_c) * WIDTH +: WIDTH];

  // Output register and round-robin pointer; a stalled word is never replaced.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_ch    <= '0;
      ptr           <= LAST;
    end else if (load_c) begin
      if (any_c) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= win_data_c;
        bus.out_ch    <= win_c;
        if (bus.mode == MODE_RR) begin
          ptr <= win_c;
        end
      end else begin
        bus.out_valid <= 1'b0;
      end
    end
  end

`ifdef ARB_MUX_STATS_EN
  logic [STAT_W-1:0] cnt [N];
  logic [N-1:0]      xfer_c;

  assign xfer_c = bus.in_valid & bus.in_ready;

  // Per-channel transfer counters, saturating at all-ones.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        if (xfer_c[i] && (cnt[i] != '1)) begin
          cnt[i] <= cnt[i] + STAT_W'(1);
        end
      end
    end
  end

  assign stat_count = (32'(stat_sel) < N) ? cnt[stat_sel] : '0;
`endif

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed and random stimulus for arb_mux_n with a reference model and an output scoreboard.
module tb_arb_mux_n;
  import arb_mux_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned N     = 5;
  localparam int unsigned SELW  = sel_w(N);

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [SELW-1:0]  ch;
  } exp_t;

  logic Clk = 1'b0;
  logic Reset;

  arb_mux_n_if #(.WIDTH(WIDTH), .N(N)) bus ();

`ifdef ARB_MUX_STATS_EN
  logic [SELW-1:0]   stat_sel;
  logic [STAT_W-1:0] stat_count;
`endif

  arb_mux_n #(.WIDTH(WIDTH), .N(N)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .bus        (bus)
`ifdef ARB_MUX_STATS_EN
    ,
    .stat_sel   (stat_sel),
    .stat_count (stat_count)
`endif
  );

  always #5 Clk = ~Clk;

  exp_t             sbq [$];
  int unsigned      total  = 0;
  int unsigned      passed = 0;
  logic [WIDTH-1:0] d [N];
  logic             m_valid;
  logic [SELW-1:0]  m_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) begin
      passed++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [N-1:0] model_gnt(input arb_mode_t md, input logic [SELW-1:0] sel,
                                             input logic [N-1:0] v, input logic [SELW-1:0] p);
    logic [N-1:0] g;
    int unsigned  ch;
    g = '0;
    if (md == MODE_DIRECT) begin
      ch = (int'(sel) < N) ? int'(sel) : N - 1;
      if (v[ch]) g[ch] = 1'b1;
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        ch = (int'(p) + k) % N;
        if (v[ch]) begin
          g[ch] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  task automatic randomize_data();
    for (int i = 0; i < N; i++) d[i] = WIDTH'($urandom);
  endtask

  // One clock: drive at negedge, check and advance the model, return just after posedge.
  task automatic tick(input logic rst, input arb_mode_t md, input logic [SELW-1:0] sel,
                      input logic [N-1:0] v, input logic rdy);
    logic [N-1:0] eg;
    logic         load;
    exp_t         e;
    @(negedge Clk);
    Reset         = rst;
    bus.mode      = md;
    bus.select    = sel;
    bus.in_valid  = v;
    bus.out_ready = rdy;
    for (int i = 0; i < N; i++) bus.in_data[i*WIDTH +: WIDTH] = d[i];
    #2;
    load = !m_valid || rdy;
    eg   = (rst || !load) ? '0 : model_gnt(md, sel, v, m_ptr);
    chk("in_ready", 32'(bus.in_ready), 32'(eg));
    chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (m_valid) begin
      if (sbq.size() == 0) begin
        chk("sb_depth", 32'(sbq.size()), 32'd1);
      end else begin
        chk("sb_data", 32'(bus.out_data), 32'(sbq[0].data));
        chk("sb_ch", 32'(bus.out_ch), 32'(sbq[0].ch));
        if (rdy && !rst) void'(sbq.pop_front());
      end
    end
    if (rst) begin
      sbq.delete();
      m_valid = 1'b0;
      m_ptr   = SELW'(N - 1);
    end else if (load) begin
      if (eg != '0) begin
        for (int i = 0; i < N; i++) begin
          if (eg[i]) begin
            e.data = d[i];
            e.ch   = SELW'(i);
            sbq.push_back(e);
            if (md == MODE_RR) m_ptr = SELW'(i);
          end
        end
        m_valid = 1'b1;
      end else begin
        m_valid = 1'b0;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset         = 1'b1;
    bus.mode      = MODE_DIRECT;
    bus.select    = '0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    m_valid       = 1'b0;
    m_ptr         = SELW'(N - 1);
`ifdef ARB_MUX_STATS_EN
    stat_sel      = '0;
`endif
    randomize_data();

    // Reset state
    tick(1'b1, MODE_DIRECT, 3'd0, 5'b00000, 1'b1);
    tick(1'b1, MODE_DIRECT, 3'd0, 5'b11111, 1'b1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_ch", 32'(bus.out_ch), 32'd0);

    // Direct select of channel 2
    d[2] = 16'hBEEF;
    tick(1'b0, MODE_DIRECT, 3'd2, 5'b00100, 1'b1);
    chk("dir2_valid", 32'(bus.out_valid), 32'd1);
    chk("dir2_data", 32'(bus.out_data), 32'hBEEF);
    chk("dir2_ch", 32'(bus.out_ch), 32'd2);

    // Out-of-range select falls back to channel 4
    randomize_data();
    d[4] = 16'h1234;
    tick(1'b0, MODE_DIRECT, 3'd7, 5'b10000, 1'b1);
    chk("dir7_data", 32'(bus.out_data), 32'h1234);
    chk("dir7_ch", 32'(bus.out_ch), 32'd4);

    // Selected channel idle: no grant even though another channel is valid
    tick(1'b0, MODE_DIRECT, 3'd1, 5'b10000, 1'b1);
    chk("dir_idle_valid", 32'(bus.out_valid), 32'd0);
    chk("dir_idle_hold", 32'(bus.out_data), 32'h1234);

    // Round robin, all channels requesting
    for (int i = 0; i < 6; i++) begin
      randomize_data();
      tick(1'b0, MODE_RR, 3'd0, 5'b11111, 1'b1);
      chk("rr_seq", 32'(bus.out_ch), 32'(i % N));
    end

    // Stall for three cycles with 16'hAAAA held
    for (int i = 0; i < N; i++) d[i] = 16'hAAAA;
    tick(1'b0, MODE_RR, 3'd0, 5'b11111, 1'b1);
    chk("stall_fill_ch", 32'(bus.out_ch), 32'd1);
    for (int i = 0; i < 3; i++) begin
      randomize_data();
      tick(1'b0, MODE_RR, 3'd0, 5'b11111, 1'b0);
      chk("stall_data", 32'(bus.out_data), 32'hAAAA);
      chk("stall_ready", 32'(bus.in_ready), 32'd0);
    end
    tick(1'b0, MODE_RR, 3'd0, 5'b11111, 1'b1);
    chk("stall_release_ch", 32'(bus.out_ch), 32'd2);

    // Reset while holding a word
    tick(1'b1, MODE_RR, 3'd0, 5'b11111, 1'b0);
    chk("midrst_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_data", 32'(bus.out_data), 32'd0);
    randomize_data();
    tick(1'b0, MODE_RR, 3'd0, 5'b11111, 1'b1);
    chk("midrst_first_rr", 32'(bus.out_ch), 32'd0);

    // Random mix of modes, selects, requests and back-pressure
    for (int i = 0; i < 60; i++) begin
      randomize_data();
      tick(1'b0, arb_mode_t'($urandom_range(0, 1)), SELW'($urandom),
           N'($urandom), 1'($urandom_range(0, 3) != 0));
    end

`ifdef ARB_MUX_STATS_EN
    tick(1'b1, MODE_DIRECT, 3'd1, 5'b00000, 1'b1);
    for (int i = 0; i < 70000; i++) begin
      tick(1'b0, MODE_DIRECT, 3'd1, 5'b00010, 1'b1);
    end
    stat_sel = 3'd1;
    #1;
    chk("stat_sat", 32'(stat_count), 32'hFFFF);
    stat_sel = 3'd7;
    #1;
    chk("stat_oor", 32'(stat_count), 32'd0);
    stat_sel = 3'd0;
    #1;
    chk("stat_ch0", 32'(stat_count), 32'd0);
`endif

    // Drain whatever is left
    tick(1'b0, MODE_DIRECT, 3'd0, 5'b00000, 1'b1);
    tick(1'b0, MODE_DIRECT, 3'd0, 5'b00000, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/arb_mux_n.md
# arb_mux_n

Parametrised, registered N-channel data multiplexer: the successor to the fixed 5-input 16-bit selector in the final-project datapath. It selects one of N WIDTH-bit input channels, either by an external select code (direct mode) or by round-robin arbitration among valid channels (RR mode). The winner is moved into a single output register under a valid/ready handshake. It sits between multiple bus masters (CPU, sprite/VGA fetch, DMA) and a shared consumer such as the memory/bus interface.

## Interface
- WIDTH, 16, data width per channel
- N, 5, number of input channels, 1..16
- SELW, max(1,$clog2(N)), width of select and channel-ID fields (derived, not overridden)
- Clk  in  1  single clock; all state updates on rising edge
- Reset  in  1  synchronous, active-high
- mode  in  1  0 = direct select, 1 = round-robin
- select  in  SELW  channel code used in direct mode
- in_valid  in  N  per-channel request
- in_data  in  N x WIDTH  per-channel data, packed channel i at [i*WIDTH +: WIDTH]
- in_ready  out  N  per-channel accept; one-hot or zero
- out_valid  out  1  output register holds data
- out_data  out  WIDTH  registered data
- out_ch  out  SELW  channel that supplied out_data
- out_ready  in  1  consumer accepts out_data
- stat_sel  in  SELW  counter read index (only with ARB_MUX_STATS_EN)
- stat_count  out  16  grant count of channel stat_sel (only with ARB_MUX_STATS_EN)

## Operation
- load = !out_valid || out_ready. Arbitration result applies only when load = 1.
- Direct mode: ch = select if select < N, else N-1, matching the legacy default-to-last-input rule. Grant ch iff in_valid[ch]; otherwise no grant.
- RR mode: search in_valid starting at ptr+1 and wrapping modulo N; the first valid channel wins. ptr is updated to the winner only on a grant.
- Direct mode never changes ptr.
- in_ready[i] = load && grant[i]. A transfer occurs when in_valid[i] && in_ready[i].
- On load with a grant: out_data <= winner data, out_ch <= winner, out_valid <= 1.
- On load with no grant: out_valid <= 0; out_data and out_ch hold.
- Simultaneous drain and refill in the same cycle is allowed. Full throughput is one word per cycle.
- Output stall (out_valid && !out_ready): out_data, out_ch and out_valid hold. All in_ready = 0.
- Changes to mode or select take effect at the next load cycle. A stalled word is never replaced.
- N = 1: the channel is always 0; the RR search is trivially 0.

## Timing
- Reset values: out_valid = 0, out_data = 0, out_ch = 0, ptr = N-1 (so the first RR search starts at channel 0), and all stat counters = 0.
- Reset asserted mid-transfer drops any held word at the next edge. in_ready is 0 while Reset = 1.
- Latency is 1 cycle from input transfer to out_valid.
- in_ready depends combinationally on out_ready, in_valid, mode and select. There is no combinational path from in_data to any output.

## Configuration
- ARB_MUX_STATS_EN defined: the block instantiates one 16-bit saturating counter per channel.
  - A counter increments on each transfer from its channel and saturates at 16'hFFFF.
  - stat_count = counter[stat_sel] combinationally. A stat_sel of N or greater reads 0.
  - Reset clears all counters.
- ARB_MUX_STATS_EN undefined: stat_sel and stat_count are absent and no counter logic is built.

## Structure
- Package arb_mux_pkg holds:
  - typedef enum logic {MODE_DIRECT, MODE_RR} arb_mode_t
  - localparam STAT_W = 16
  - localparam N_MAX = 16
- Sub-module rr_picker (parameter N) is a combinational rotate-priority search. Inputs: req[N] and ptr. Outputs: gnt_onehot, gnt_idx and any.

## Test plan
- Reset, then direct mode, select=2, in_valid=5'b00100, in_data[2]=16'hBEEF, out_ready=1 -> in_ready=5'b00100; next cycle out_valid=1, out_data=16'hBEEF, out_ch=2.
- Direct mode, select=3'd7, N=5, in_valid[4]=1, data 16'h1234 -> channel 4 granted; out_data=16'h1234.
- RR mode, all 5 channels valid continuously, out_ready=1 -> out_ch sequence 0,1,2,3,4,0, one grant per cycle.
- RR mode, out_ready held 0 for 3 cycles with out_data=16'hAAAA -> output holds 16'hAAAA, in_ready=0, ptr unchanged; on release, the next channel follows in rotation.
- Reset asserted while out_valid=1 and in_valid=5'b11111 -> next cycle out_valid=0, out_data=0, and the first RR grant after release is channel 0.
- With ARB_MUX_STATS_EN: 70000 grants to channel 1 -> stat_sel=1 gives stat_count=16'hFFFF; stat_sel=7 gives 0.
